// File: rtl/serial_add_scheduler.sv
// Operand FIFO, control sequencer and result register wrapped around an
// external bit-serial adder. Optional SHIFT timeout is built only when SAS_TIMEOUT_EN is defined.
module serial_add_scheduler #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int LOAD_CYCLES = 1,
    parameter int TIMEOUT     = WIDTH + 4
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_write,
    output logic                     add_clr,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    input  logic                     add_stop
);

    // state | meaning
    // IDLE  | adder held in clear; waits for a queued pair
    // LOAD  | add_write strobe held for LOAD_CYCLES cycles
    // SHIFT | adder running; waits for add_stop (or timeout)
    // HOLD  | adder finished, result slot still occupied
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_HOLD} state_t;

    localparam int PW  = $clog2(DEPTH);
    localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_a_d [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] mem_b_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      level_q, level_d;

    logic [WIDTH-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
    logic [LCW-1:0]   load_cnt_q, load_cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;

    logic push, start, capture, slot_free, done, tmo_hit;

    assign in_ready  = (level_q != (PW+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    assign slot_free = !res_valid_q || res_ready;
    assign start     = (state_q == S_IDLE) && (level_q != '0);
    assign done      = add_stop || tmo_hit;

    always_comb begin
        mem_a_d  = mem_a_q;
        mem_b_d  = mem_b_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (capture) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, capture})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (load_cnt_q == '0) state_d = S_SHIFT;
            S_SHIFT: if (done) state_d = slot_free ? S_IDLE : S_HOLD;
            S_HOLD:  if (slot_free) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        add_clr   = 1'b0;
        add_write = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE:  add_clr   = 1'b1;
            S_LOAD:  add_write = 1'b1;
            S_SHIFT: capture   = done && slot_free;
            S_HOLD:  capture   = slot_free;
            default: capture   = 1'b0;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // A capture may coincide with the consumer taking the old result; valid then stays high.
    always_comb begin
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        load_cnt_d  = load_cnt_q;
        res_valid_d = capture || (res_valid_q && !res_ready);
        res_sum_d   = capture ? add_sum  : res_sum_q;
        res_cout_d  = capture ? add_cout : res_cout_q;
        if (start) begin
            add_a_d    = mem_a_q[rd_ptr_q];
            add_b_d    = mem_b_q[rd_ptr_q];
            load_cnt_d = LCW'(LOAD_CYCLES - 1);
        end else if ((state_q == S_LOAD) && (load_cnt_q != '0)) begin
            load_cnt_d = load_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mem_a_q     <= '{default: '0};
            mem_b_q     <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            load_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
        end else begin
            mem_a_q     <= mem_a_d;
            mem_b_q     <= mem_b_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            load_cnt_q  <= load_cnt_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
        end
    end

`ifdef SAS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_pend_q, err_pend_d;
    logic          res_err_q, res_err_d;

    // err_pend remembers whether SHIFT ended by timeout, for a capture deferred to HOLD.
    always_comb begin
        tmo_cnt_d  = tmo_cnt_q;
        err_pend_d = err_pend_q;
        res_err_d  = res_err_q;
        if (state_q == S_LOAD) tmo_cnt_d = TW'(TIMEOUT - 1);
        else if ((state_q == S_SHIFT) && (tmo_cnt_q != '0)) tmo_cnt_d = tmo_cnt_q - 1'b1;
        if (state_q == S_SHIFT) err_pend_d = !add_stop;
        if (capture) res_err_d = (state_q == S_HOLD) ? err_pend_q : !add_stop;
    end

    assign tmo_hit = (state_q == S_SHIFT) && (tmo_cnt_q == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tmo_cnt_q  <= '0;
            err_pend_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            err_pend_q <= err_pend_d;
            res_err_q  <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    assign tmo_hit = 1'b0;
    assign res_err = 1'b0;
`endif

    assign level     = level_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler with a behavioural bit-serial adder;
// the timeout step follows SAS_TIMEOUT_EN when it is defined for the build.
module tb_serial_add_scheduler;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int LOAD_CYCLES = 1;
    localparam int TIMEOUT     = WIDTH + 4;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_err;
    logic             busy;
    logic [$clog2(DEPTH):0] level;
    logic [WIDTH-1:0] add_a, add_b;
    logic             add_write, add_clr;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout, add_stop;

    int checks = 0;
    int failures = 0;

    serial_add_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .clr_n(clr_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_cout(res_cout), .res_err(res_err), .busy(busy), .level(level),
        .add_a(add_a), .add_b(add_b), .add_write(add_write), .add_clr(add_clr),
        .add_sum(add_sum), .add_cout(add_cout), .add_stop(add_stop)
    );

    always #5 clk = ~clk;

    // Behavioural adder: loads on add_write, raises sticky stop after WIDTH shift cycles.
    logic [WIDTH-1:0] m_a, m_b, m_sum;
    logic             m_cout, m_stop, stop_en;
    int               m_cnt;

    always @(posedge clk) begin
        if (add_clr) begin
            m_cnt <= 0; m_stop <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
        end else if (add_write) begin
            m_a <= add_a; m_b <= add_b; m_cnt <= 0; m_stop <= 1'b0;
        end else if (!m_stop && stop_en) begin
            if (m_cnt == WIDTH - 1) begin
                m_stop <= 1'b1;
                {m_cout, m_sum} <= {1'b0, m_a} + {1'b0, m_b};
            end
            m_cnt <= m_cnt + 1;
        end
    end

    assign add_sum  = m_sum;
    assign add_cout = m_cout;
    assign add_stop = m_stop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, wr, clr_lo, ops, idle, nres, peak, bcnt, vcnt;
        logic prev_w, got;
        logic [WIDTH-1:0] q_sum [$];
        logic             q_cout [$];

        clr_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        res_ready = 1'b1; stop_en = 1'b1;
        step(); step();
        clr_n = 1'b1;
        step();

        // reset values
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_cout", res_cout, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_write", add_write, 0);
        chk("rst_add_clr", add_clr, 1);

        // single operation 123+145 = 268
        push1(8'd123, 8'd145);
        chk("t1_level_after_push", level, 1);
        chk("t1_idle_write", add_write, 0);
        step();
        chk("t1_load_write", add_write, 1);
        chk("t1_load_clr", add_clr, 0);
        chk("t1_add_a", add_a, 123);
        chk("t1_add_b", add_b, 145);
        wr = 1; clr_lo = 1; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (res_valid) begin got = 1'b1; break; end
            wr += int'(add_write);
            clr_lo += int'(!add_clr);
        end
        chk("t1_result_seen", got, 1);
        chk("t1_write_cycles", wr, LOAD_CYCLES);
        chk("t1_clr_low_cycles", clr_lo, LOAD_CYCLES + WIDTH + 1);
        chk("t1_sum", res_sum, 12);
        chk("t1_cout", res_cout, 1);
        chk("t1_err", res_err, 0);
        chk("t1_busy_at_capture", busy, 0);
        chk("t1_level_at_capture", level, 0);
        step();
        chk("t1_valid_consumed", res_valid, 0);

        // back-to-back: 123+145 then 16+48
        in_valid = 1'b1; in_a = 8'd123; in_b = 8'd145;
        step();
        in_a = 8'd16; in_b = 8'd48;
        step();
        in_valid = 1'b0;
        ops = 0; idle = 0; prev_w = 1'b0;
        q_sum.delete(); q_cout.delete();
        for (int i = 0; i < 80 && q_sum.size() < 2; i++) begin
            if (add_write && !prev_w) ops++;
            prev_w = add_write;
            if (ops == 1 && add_clr) idle++;
            if (res_valid && res_ready) begin q_sum.push_back(res_sum); q_cout.push_back(res_cout); end
            step();
        end
        chk("t2_count", q_sum.size(), 2);
        if (q_sum.size() == 2) begin
            chk("t2_sum0", q_sum[0], 12);
            chk("t2_cout0", q_cout[0], 1);
            chk("t2_sum1", q_sum[1], 64);
            chk("t2_cout1", q_cout[1], 0);
        end
        chk("t2_idle_between", idle, 1);
        for (int i = 0; i < 5; i++) step();

        // backpressure: 5 pushes into a 4-deep FIFO
        res_ready = 1'b0;
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = WIDTH'(2*k + 1); in_b = WIDTH'(2*k + 2);
            step();
            if (int'(level) > peak) peak = int'(level);
        end
        chk("t3_level_full", level, 4);
        chk("t3_in_ready_full", in_ready, 0);
        in_a = 8'd9; in_b = 8'd10;
        step();
        in_valid = 1'b0;
        chk("t3_fifth_refused", level, 4);
        for (int i = 0; i < 40; i++) begin
            step();
            if (int'(level) > peak) peak = int'(level);
        end
        chk("t3_peak", peak, 4);
        chk("t3_hold_valid", res_valid, 1);
        chk("t3_hold_sum", res_sum, 3);
        chk("t3_hold_level", level, 3);
        chk("t3_hold_busy", busy, 1);
        chk("t3_hold_write", add_write, 0);
        chk("t3_hold_clr", add_clr, 0);
        res_ready = 1'b1;
        q_sum.delete(); q_cout.delete();
        for (int i = 0; i < 120; i++) begin
            if (res_valid && res_ready) begin q_sum.push_back(res_sum); q_cout.push_back(res_cout); end
            step();
        end
        chk("t3_count", q_sum.size(), 4);
        if (q_sum.size() == 4) begin
            chk("t3_sum0", q_sum[0], 3);
            chk("t3_sum1", q_sum[1], 7);
            chk("t3_sum2", q_sum[2], 11);
            chk("t3_sum3", q_sum[3], 15);
        end
        chk("t3_level_end", level, 0);
        chk("t3_busy_end", busy, 0);

        // adder never finishes
        stop_en = 1'b0;
        push1(8'd1, 8'd1);
`ifdef SAS_TIMEOUT_EN
        s = 0; got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (res_valid) begin got = 1'b1; break; end
            step();
            s++;
        end
        chk("t4_timeout_seen", got, 1);
        chk("t4_timeout_cycle", s, LOAD_CYCLES + 1 + TIMEOUT);
        chk("t4_timeout_err", res_err, 1);
        step();
        chk("t4_timeout_idle", busy, 0);
        chk("t4_timeout_consumed", res_valid, 0);
`else
        bcnt = 0; vcnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            bcnt += int'(busy);
            vcnt += int'(res_valid);
        end
        chk("t4_busy_held", bcnt, 100);
        chk("t4_no_result", vcnt, 0);
        chk("t4_err_tied", res_err, 0);
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        step();
`endif
        stop_en = 1'b1;

        // reset mid-SHIFT with two pairs queued behind the active one
        in_valid = 1'b1; in_a = 8'd50; in_b = 8'd60;
        step();
        in_a = 8'd70; in_b = 8'd80;
        step();
        in_a = 8'd90; in_b = 8'd100;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t5_busy_before", busy, 1);
        chk("t5_level_before", level, 3);
        clr_n = 1'b0;
        #1;
        chk("t5_level", level, 0);
        chk("t5_add_clr", add_clr, 1);
        chk("t5_res_valid", res_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_add_a", add_a, 0);
        step();
        clr_n = 1'b1;
        bcnt = 0; vcnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            bcnt += int'(busy);
            vcnt += int'(res_valid);
        end
        chk("t5_no_busy_after", bcnt, 0);
        chk("t5_no_result_after", vcnt, 0);

        // recovery after reset: 200+100 = 300
        push1(8'd200, 8'd100);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin got = 1'b1; break; end
            step();
        end
        chk("t6_result_seen", got, 1);
        chk("t6_sum", res_sum, 44);
        chk("t6_cout", res_cout, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
